// File: rtl/bench_ce_pipeline.sv
`default_nettype none
// ============================================================================
// Module      : bench_ce_pipeline
// Description : NCH-channel two-stage XOR pipeline advanced by a selectable
//               clock-enable divider; rate changes only at period boundaries.
// Revision    : 1.0 - initial release
// ============================================================================
module bench_ce_pipeline #(
    parameter int NCH   = 4,
    parameter int W     = 3,
    parameter int DIV_A = 2,
    parameter int DIV_B = 3,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             sel,
    input  logic [NCH*W-1:0] in_data,
    input  logic [NCH-1:0]   in_gate,
    output logic             ce,
    output logic             ce_active,
    output logic             sel_ack,
    output logic [NCH-1:0]   out_and,
    output logic [NCH-1:0]   out_inv
);

    if (DIV_A < 1 || DIV_A > (1 << CNT_W)) begin : g_bad_div_a
        $error("bench_ce_pipeline: DIV_A out of range for CNT_W");
    end
    if (DIV_B < 1 || DIV_B > (1 << CNT_W)) begin : g_bad_div_b
        $error("bench_ce_pipeline: DIV_B out of range for CNT_W");
    end
    if (W < 1) begin : g_bad_w
        $error("bench_ce_pipeline: W must be at least 1");
    end

    localparam logic [CNT_W-1:0] LAST_A = CNT_W'(DIV_A - 1);
    localparam logic [CNT_W-1:0] LAST_B = CNT_W'(DIV_B - 1);

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] last;
    logic             sel_q;
    logic [NCH-1:0]   s1;
    logic [NCH-1:0]   s2;
    logic [NCH-1:0]   parity;
    logic [NCH-1:0]   tap;

    assign last = ce_active ? LAST_B : LAST_A;
    assign ce   = (cnt == last) && !reset;

    // A pending rate change is only committed on a ce cycle, so the period
    // in progress always completes at the old rate.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt       <= '0;
            sel_q     <= 1'b0;
            ce_active <= 1'b0;
            sel_ack   <= 1'b0;
        end else begin
            sel_q   <= sel;
            sel_ack <= 1'b0;
            if (ce) begin
                cnt <= '0;
                if (sel_q != ce_active) begin
                    ce_active <= sel_q;
                    sel_ack   <= 1'b1;
                end
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        assign parity[i] = ^in_data[i*W +: W];
        assign tap[i]    = in_data[i*W];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s1 <= '0;
            s2 <= '0;
        end else if (ce) begin
            s1 <= parity;
            s2 <= s1 ^ tap;
        end
    end

    assign out_and = s2 & in_gate;
    assign out_inv = ~s1;

endmodule
`default_nettype wire
